// File: rtl/pc_unit.sv
// Program-counter unit: sequential step, stall, redirect, call/return through a
// small circular return-address stack with overflow/underflow fault pulse.
module pc_unit #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned STEP         = 1,
  parameter int unsigned RESET_VECTOR = 0,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Stall,
  input  logic             Redirect,
  input  logic             Call,
  input  logic             Return,
  input  logic [WIDTH-1:0] Target,
  output logic [WIDTH-1:0] PcOutput,
  output logic [WIDTH-1:0] PcPlusStep,
  output logic             RasEmpty,
  output logic             RasFull,
  output logic             RasFault
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [WIDTH-1:0] RST_PC   = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] STEP_VAL = WIDTH'(STEP);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0] top_q, top_d, top_m1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic             empty_q, full_q;
  logic             ras_we;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  // top_q points at the next free slot; the newest entry sits just below it
  assign top_m1     = top_q - PTR_W'(1);
  assign PcPlusStep = pc_q + STEP_VAL;

  // One action per edge, highest priority first
  always_comb begin
    pc_d    = pc_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    fault_d = 1'b0;
    ras_we  = 1'b0;
    if (Stall) begin
      pc_d = pc_q;
    end else if (Return) begin
      if (cnt_q != '0) begin
        pc_d  = ras_mem[top_m1];
        top_d = top_m1;
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        pc_d    = RST_PC;
        fault_d = 1'b1;
      end
    end else if (Call) begin
      // When full, the slot at top_q holds the oldest entry and is overwritten
      ras_we = 1'b1;
      top_d  = top_q + PTR_W'(1);
      pc_d   = Target;
      if (cnt_q == CNT_MAX) begin
        fault_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (Redirect) begin
      pc_d = Target;
    end else begin
      pc_d = PcPlusStep;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc_q    <= RST_PC;
      top_q   <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == CNT_MAX);
    end
  end

  // Stack storage needs no reset; the count qualifies every read
  always_ff @(posedge Clk) begin
    if (ras_we) begin
      ras_mem[top_q] <= PcPlusStep;
    end
  end

  assign PcOutput = pc_q;
  assign RasEmpty = empty_q;
  assign RasFull  = full_q;
  assign RasFault = fault_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: stepping, wrap, call/return, RAS overflow and
// underflow, stall priority and asynchronous reset.
module tb_pc_unit;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Stall, Redirect, Call, Return;
  logic [15:0] Target;
  logic [15:0] PcOutput, PcPlusStep;
  logic        RasEmpty, RasFull, RasFault;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  pc_unit #(.WIDTH(16), .STEP(1), .RESET_VECTOR(0), .RAS_DEPTH(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Redirect(Redirect),
    .Call(Call), .Return(Return), .Target(Target),
    .PcOutput(PcOutput), .PcPlusStep(PcPlusStep),
    .RasEmpty(RasEmpty), .RasFull(RasFull), .RasFault(RasFault)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Stall = 1'b0; Redirect = 1'b0; Call = 1'b0; Return = 1'b0; Target = 16'h0000;
  endtask

  task automatic jump(input logic [15:0] t);
    Redirect = 1'b1; Target = t;
    tick();
    Redirect = 1'b0;
    check("jump_pc", 32'(PcOutput), 32'(t));
  endtask

  logic [15:0] ret_exp [4];

  initial begin
    idle_inputs();
    Rst_n = 1'b0;
    #12;
    check("rst_pc", 32'(PcOutput), 32'h0);
    check("rst_pps", 32'(PcPlusStep), 32'h1);
    check("rst_empty", 32'(RasEmpty), 32'h1);
    check("rst_full", 32'(RasFull), 32'h0);
    check("rst_fault", 32'(RasFault), 32'h0);
    #10 Rst_n = 1'b1;

    // Sequential stepping from the reset vector
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("step%0d", i), 32'(PcOutput), 32'(i));
      check($sformatf("step%0d_empty", i), 32'(RasEmpty), 32'h1);
    end

    // Increment wraps modulo 2^16 without a fault
    jump(16'hFFFE);
    tick();
    check("wrap_ffff", 32'(PcOutput), 32'hFFFF);
    check("wrap_pps", 32'(PcPlusStep), 32'h0000);
    check("wrap_fault0", 32'(RasFault), 32'h0);
    tick();
    check("wrap_0000", 32'(PcOutput), 32'h0000);
    check("wrap_fault1", 32'(RasFault), 32'h0);

    // Call immediately followed by return
    jump(16'h0010);
    Call = 1'b1; Target = 16'h0200;
    tick();
    check("call_pc", 32'(PcOutput), 32'h0200);
    check("call_empty", 32'(RasEmpty), 32'h0);
    Call = 1'b0; Return = 1'b1;
    tick();
    Return = 1'b0;
    check("ret_pc", 32'(PcOutput), 32'h0011);
    check("ret_empty", 32'(RasEmpty), 32'h1);
    check("ret_fault", 32'(RasFault), 32'h0);

    // Five nested calls overflow a four-entry stack
    for (int i = 1; i <= 5; i++) begin
      jump(16'(i * 16));
      Call = 1'b1; Target = 16'h1000 + 16'(i);
      tick();
      Call = 1'b0;
      check($sformatf("nest%0d_pc", i), 32'(PcOutput), 32'h1000 + 32'(i));
      check($sformatf("nest%0d_fault", i), 32'(RasFault), (i == 5) ? 32'h1 : 32'h0);
      check($sformatf("nest%0d_full", i), 32'(RasFull), (i >= 4) ? 32'h1 : 32'h0);
    end
    ret_exp[0] = 16'h0051; ret_exp[1] = 16'h0041;
    ret_exp[2] = 16'h0031; ret_exp[3] = 16'h0021;
    Return = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("pop%0d_pc", i), 32'(PcOutput), 32'(ret_exp[i]));
      check($sformatf("pop%0d_fault", i), 32'(RasFault), 32'h0);
      check($sformatf("pop%0d_full", i), 32'(RasFull), 32'h0);
      check($sformatf("pop%0d_empty", i), 32'(RasEmpty), (i == 3) ? 32'h1 : 32'h0);
    end
    tick();
    check("underflow_pc", 32'(PcOutput), 32'h0);
    check("underflow_fault", 32'(RasFault), 32'h1);
    Return = 1'b0;
    tick();
    check("underflow_clear", 32'(RasFault), 32'h0);
    check("underflow_step", 32'(PcOutput), 32'h1);

    // Call with Return on an empty stack acts as a faulting return only
    jump(16'h0700);
    Call = 1'b1; Return = 1'b1; Target = 16'h0900;
    tick();
    Call = 1'b0; Return = 1'b0;
    check("callret_pc", 32'(PcOutput), 32'h0);
    check("callret_fault", 32'(RasFault), 32'h1);
    check("callret_empty", 32'(RasEmpty), 32'h1);

    // Stall dominates a pending redirect
    jump(16'h0100);
    Stall = 1'b1; Redirect = 1'b1; Target = 16'h0ABC;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d_pc", i), 32'(PcOutput), 32'h0100);
      check($sformatf("stall%0d_fault", i), 32'(RasFault), 32'h0);
    end
    Stall = 1'b0;
    tick();
    Redirect = 1'b0;
    check("unstall_pc", 32'(PcOutput), 32'h0ABC);

    // Asynchronous reset between edges with two entries on the stack
    jump(16'h0030);
    Call = 1'b1; Target = 16'h0400;
    tick();
    Target = 16'h0500;
    tick();
    Call = 1'b0;
    check("prerst_pc", 32'(PcOutput), 32'h0500);
    check("prerst_empty", 32'(RasEmpty), 32'h0);
    #2 Rst_n = 1'b0;
    #1;
    check("async_pc", 32'(PcOutput), 32'h0);
    check("async_empty", 32'(RasEmpty), 32'h1);
    check("async_full", 32'(RasFull), 32'h0);
    #2 Rst_n = 1'b1;
    tick();
    check("postrst_pc", 32'(PcOutput), 32'h1);
    Return = 1'b1;
    tick();
    Return = 1'b0;
    check("postrst_ret_pc", 32'(PcOutput), 32'h0);
    check("postrst_ret_fault", 32'(RasFault), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
